// File: rtl/aes_tiled_seq.sv
// Sequential AES round helper: SubBytes / SubBytes+ShiftRows half / MixColumns on
// two 32-bit operands, LANES result bytes per cycle through shared S-box and mix units.
package aes_tiled_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 = product of x^(2^i) for i = 1..7; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
endpackage

module aes_fwd_sbox
  import aes_tiled_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] t;
  assign t    = gf_inv(din);
  assign dout = t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
endmodule

module aes_inv_sbox
  import aes_tiled_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] t;
  assign t    = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
  assign dout = gf_inv(t);
endmodule

module aes_mixcolumn_byte
  import aes_tiled_pkg::*;
(
  input  logic [31:0] col,
  input  logic        dec,
  output logic [7:0]  dout
);
  logic [7:0] b0, b1, b2, b3;
  assign {b3, b2, b1, b0} = col;
  assign dout = dec ? (gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09))
                    : (xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3);
endmodule

module aes_tiled_seq #(
  parameter int DECRYPT_EN = 1,
  parameter int LANES      = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        dec,
  input  logic        op_sb,
  input  logic        op_sbsr,
  input  logic        op_mix,
  input  logic        hi,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rd,
  output logic        dbg_state
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OP_SBSR = 2'd0, OP_SB = 2'd1, OP_MIX = 2'd2} op_t;

  localparam logic [1:0] K_LAST = 2'(4 / LANES - 1);

  state_t      state, state_nxt;
  op_t         op_q, op_in;
  logic [1:0]  k_q;
  logic [31:0] rs1_q, rs2_q;
  logic        hi_q, dec_q;
  logic        accept, last;
  logic [31:0] sb_src;
  logic [31:0] cols [4];
  logic [7:0]  lane_res [LANES];
  logic [1:0]  lane_idx [LANES];

  // Handshake: valid is only looked at in IDLE (no queuing while BUSY); ready is a
  // one-cycle completion pulse with no backpressure, and IDLE already accepts during it.
  assign accept    = (state == IDLE) && valid;
  assign last      = (state == BUSY) && (k_q == K_LAST);
  assign busy      = (state == BUSY);
  assign dbg_state = (state == BUSY);

  assign op_in = op_mix ? OP_MIX :
                 (op_sbsr && !op_sb) ? OP_SBSR :
                 op_sb ? OP_SB : OP_SBSR;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= IDLE;
      k_q   <= 2'd0;
      ready <= 1'b0;
      rd    <= 32'h0;
      rs1_q <= 32'h0;
      rs2_q <= 32'h0;
      op_q  <= OP_SBSR;
      hi_q  <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= last;
      if (accept) begin
        k_q   <= 2'd0;
        rs1_q <= rs1;
        rs2_q <= rs2;
        op_q  <= op_in;
        hi_q  <= hi;
        dec_q <= dec && (DECRYPT_EN != 0);
      end else if (state == BUSY) begin
        k_q <= k_q + 2'd1;
        for (int l = 0; l < LANES; l++) rd[{lane_idx[l], 3'b000} +: 8] <= lane_res[l];
      end
    end
  end

  // Byte i of sb_src is the S-box input that lands in rd byte i (ShiftRows folded in).
  always_comb begin
    sb_src = rs1_q;
    if (op_q == OP_SBSR) begin
      case ({dec_q, hi_q})
        2'b00:   sb_src = {rs1_q[15:8], rs1_q[23:16], rs2_q[31:24], rs1_q[7:0]};
        2'b01:   sb_src = {rs2_q[15:8], rs2_q[23:16], rs1_q[31:24], rs2_q[7:0]};
        2'b10:   sb_src = {rs2_q[15:8], rs1_q[23:16], rs1_q[31:24], rs1_q[7:0]};
        default: sb_src = {rs1_q[15:8], rs2_q[23:16], rs2_q[31:24], rs2_q[7:0]};
      endcase
    end
  end

  always_comb begin
    cols[0] = {rs1_q[7:0], rs1_q[15:8], rs2_q[7:0], rs2_q[15:8]};
    cols[2] = {rs1_q[23:16], rs1_q[31:24], rs2_q[23:16], rs2_q[31:24]};
    cols[1] = {cols[0][23:0], cols[0][31:24]};
    cols[3] = {cols[2][23:0], cols[2][31:24]};
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] sb_in, fwd_out, inv_out, mix_out;

    assign lane_idx[l] = 2'(int'(k_q) * LANES + l);
    assign sb_in       = sb_src[{lane_idx[l], 3'b000} +: 8];

    aes_fwd_sbox u_fwd (.din(sb_in), .dout(fwd_out));

    if (DECRYPT_EN != 0) begin : g_inv
      aes_inv_sbox u_inv (.din(sb_in), .dout(inv_out));
    end else begin : g_no_inv
      assign inv_out = fwd_out;
    end

    aes_mixcolumn_byte u_mix (.col(cols[lane_idx[l]]), .dec(dec_q), .dout(mix_out));

    assign lane_res[l] = (op_q == OP_MIX) ? mix_out :
                         ((op_q == OP_SBSR) && dec_q) ? inv_out : fwd_out;
  end
endmodule

// File: doc/aes_tiled_seq.md
AES_TILED_SEQ -- requirements
Module: aes_tiled_seq

Interface
REQ-001 The block SHALL have parameter DECRYPT_EN, default 1, meaning inverse S-box and inverse MixColumn logic are present; when 0, the dec input is ignored.
REQ-002 The block SHALL have parameter LANES, default 1, legal values 1, 2 or 4, giving the number of result bytes computed per cycle.
REQ-003 g_clk  input  1  clock; all state updates on the rising edge.
REQ-004 g_resetn  input  1  reset; synchronous and active-low.
REQ-005 valid  input  1  request strobe; operands and op inputs are sampled when accepted.
REQ-006 dec  input  1  0 = encrypt, 1 = decrypt.
REQ-007 op_sb  input  1  SubBytes only.
REQ-008 op_sbsr  input  1  SubBytes plus ShiftRows half.
REQ-009 op_mix  input  1  MixColumns.
REQ-010 hi  input  1  selects the high or low ShiftRows half.
REQ-011 rs1, rs2  input  32 each  source operands.
REQ-012 busy  output  1  high while a request is in flight.
REQ-013 ready  output  1  one-cycle pulse marking rd valid.
REQ-014 rd  output  32  result register.

Function
REQ-015 Op priority SHALL be op_mix > op_sb > sbsr, with sbsr as the default when no op bit is set; decrypt SHALL be dec AND DECRYPT_EN.
REQ-016 The FSM SHALL have states IDLE and BUSY; a request is accepted in IDLE when valid=1, which captures rs1, rs2, op, hi and decrypt, clears step counter k to 0 and moves to BUSY.
REQ-017 valid while BUSY SHALL be ignored, with no queuing; inputs changing after acceptance SHALL NOT affect the result.
REQ-018 Each BUSY cycle SHALL write rd bytes k*LANES .. k*LANES+LANES-1 and increment k; on the cycle k = 4/LANES-1 the FSM SHALL return to IDLE and ready SHALL pulse in the following cycle.
REQ-019 Latency SHALL be fixed: ready rises exactly 4/LANES+1 cycles after the accepting edge (2 cycles for LANES=4, 5 cycles for LANES=1).
REQ-020 A new request SHALL be acceptable in the same cycle that ready is high, giving back-to-back throughput of one request per 4/LANES+1 cycles.
REQ-021 Bytes of rd not yet written SHALL retain their old values; rd SHALL be stable from ready until the next accepted request writes it.
REQ-022 The block SHALL instantiate exactly LANES aes_fwd_sbox, LANES aes_inv_sbox (only when DECRYPT_EN=1) and LANES aes_mixcolumn_byte units, time-multiplexed across steps.
REQ-023 op_sb: rd byte i SHALL equal S(rs1 byte i).
REQ-024 sbsr forward, hi=0: rd = {S(rs1b1), S(rs1b2), S(rs2b3), S(rs1b0)} (byte 3 first).
REQ-025 sbsr forward, hi=1: rd = {S(rs2b1), S(rs2b2), S(rs1b3), S(rs2b0)}.
REQ-026 sbsr inverse, hi=0: rd = {Si(rs2b1), Si(rs1b2), Si(rs1b3), Si(rs1b0)}.
REQ-027 sbsr inverse, hi=1: rd = {Si(rs1b1), Si(rs2b2), Si(rs2b3), Si(rs2b0)}.
REQ-028 op_sb SHALL always use the forward S-box regardless of dec.
REQ-029 With DECRYPT_EN=0 and dec=1, sbsr SHALL behave as forward sbsr.
REQ-030 op_mix: with C0 = {rs1b0, rs1b1, rs2b0, rs2b1} and C1 = {rs1b2, rs1b3, rs2b2, rs2b3}, rd byte 0 = M(C0), byte 1 = M(rot8(C0)), byte 2 = M(C1), byte 3 = M(rot8(C1)).
REQ-031 M in REQ-030 is the aes_mixcolumn_byte function in the selected direction, and rot8 moves the top byte to the bottom.

Reset
REQ-032 While g_resetn=0 at a clock edge: state = IDLE, k = 0, busy = 0, ready = 0, rd = 0 and captured operands = 0.
REQ-033 Reset asserted mid-request SHALL abort the request with no ready pulse; the first request after reset SHALL complete normally.

Verification
REQ-034 LANES=1, op_sb, dec=0, rs1=0x00005300 -> ready at accept+5, rd=0x6363ED63, busy high for 4 cycles.
REQ-035 LANES=4, sbsr hi=0 fwd, rs1=0x03020100, rs2=0x07060504 -> ready at accept+2, rd=0x7C77C563.
REQ-036 LANES=2, op_mix, rs1=rs2=0x01010101 -> rd=0x01010101 with dec=0 and with dec=1, ready at accept+3.
REQ-037 LANES=1, second valid held during BUSY -> ignored; request re-issued on the ready cycle is accepted, and rd holds the first result until overwritten.
REQ-038 LANES=2, reset at accept+1 -> no ready pulse, rd=0, next request correct.
REQ-039 DECRYPT_EN=0, sbsr dec=1 hi=0 with REQ-035 operands -> rd=0x7C77C563.
